store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Memory-side writer for register data; the counterpart of the load/write-back path.
- Takes the store source register, the effective address and the store size (SW/SH/SB), and performs the memory write.
- SW is written directly. SH and SB use a read-modify-write so the untouched bytes of the word are preserved.
- Sits between the control unit and data memory. Memory has registered reads with 1-cycle latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width; fixed at 32, since lane logic assumes 4 bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- store_type  in  2  0=SW, 1=SH, 2=SB, 3=reserved
- addr  in  32  effective byte address
- wdata  in  32  store source register value
- mem_rdata  in  32  memory read data; valid the cycle after address is presented
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wr  out  1  memory write strobe
- mem_wdata  out  32  word to write
- busy  out  1  high from the cycle after an accepted start through DONE/ERR
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on a rejected request

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; latched addr, data and type cleared.
- Byte order: little-endian; byte k of a word is bits [8k+7:8k].
- Accept: start=1 in IDLE latches addr, wdata and store_type. start in any other state is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WRITE, DONE, ERR.
- Transitions:
  - IDLE + start, SW -> WRITE
  - IDLE + start, SH/SB -> RD_REQ
  - IDLE + start, type 3 -> ERR
  - RD_REQ -> RD_WAIT
  - RD_WAIT -> WRITE
  - WRITE -> DONE
  - DONE -> IDLE
  - ERR -> IDLE
- RD_REQ: mem_addr = word address, mem_wr = 0.
- RD_WAIT: mem_rdata is captured at the end of this cycle into the merge register.
- WRITE: mem_wr = 1 for exactly one cycle; mem_addr = word address.
  - SW: mem_wdata = wdata.
  - SH: halfword addr[1] replaced by wdata[15:0].
  - SB: byte addr[1:0] replaced by wdata[7:0].
  - All other lanes come from the captured read word.
- Latency from the start cycle: SW done at +2; SH/SB done at +4; ERR done+err at +1.
- busy deasserts in the cycle after DONE/ERR. Back-to-back: start may be asserted in the first IDLE cycle after DONE.
- mem_wr is never asserted outside WRITE.
- Reset mid-operation: next edge returns to IDLE with mem_wr=0; no partial write, no done.
- Memory interface outputs are registered; mem_wdata holds its value outside WRITE and is don't-care there.

Optional Feature:
- Macro: STORE_MISALIGN_CHECK_EN.
- Defined:
  - SH with addr[0]=1, or SW with addr[1:0]!=0 -> ERR state.
  - done=1 and err=1 for one cycle, no memory access.
- Undefined:
  - Low address bits are masked: SH uses addr[1] only, SW ignores addr[1:0].
  - err is asserted only for type 3.

Decomposition:
- store_pkg holds:
  - typedef enum store_type_t {ST_SW, ST_SH, ST_SB, ST_RSV}
  - typedef enum state_t
  - lane width constants.
- Sub-module store_merge: purely combinational lane insertion (old_word, wdata, type, addr[1:0]) -> new_word. It is instantiated once and verifiable standalone.

Test Plan:
- SW, addr=0x100, wdata=0xDEADBEEF -> one mem_wr at cycle 1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done at cycle 2, no read phase.
- SB, addr=0x102, wdata=0x000000AA, memory word 0x11223344 -> write 0x11AA3344 at cycle 3, done at cycle 4.
- SH, addr=0x206, wdata=0x0000CAFE, memory word 0x55667788 -> write 0xCAFE7788.
- store_type=3 -> done=1 and err=1 at cycle 1, mem_wr never asserted. SH at addr=0x201 with STORE_MISALIGN_CHECK_EN -> same response; without the macro -> writes halfword 0.
- Reset asserted during RD_WAIT of an SB -> no mem_wr, no done. The next SW after reset completes normally.
- start held high during an SH -> ignored while busy. A new start in the first IDLE cycle after DONE is accepted.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types and lane constants for the store unit.
// Optional build macro: STORE_MISALIGN_CHECK_EN.
package store_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int NBYTES = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_SW  = 2'd0,
    ST_SH  = 2'd1,
    ST_SB  = 2'd2,
    ST_RSV = 2'd3
  } store_type_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

endpackage

// File: rtl/store_merge.sv
// Combinational lane insertion of store data into a word.
// Little-endian: byte k lives in bits [8k+7:8k].
module store_merge
  import store_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] wdata,
  input  store_type_t       stype,
  input  logic [1:0]        lo,
  output logic [WORD_W-1:0] new_word
);

  always_comb begin
    new_word = old_word;
    unique case (stype)
      ST_SW: new_word = wdata;
      ST_SH: begin
        if (lo[1])
          new_word[HALF_W +: HALF_W] = wdata[HALF_W-1:0];
        else
          new_word[0 +: HALF_W] = wdata[HALF_W-1:0];
      end
      ST_SB: new_word[{lo, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      default: new_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: SW direct write, SH/SB read-modify-write.
// Optional build macro: STORE_MISALIGN_CHECK_EN.
module store_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  store_type_t       type_q;

  store_type_t       t_in;
  store_type_t       t_sel;
  logic [ADDR_W-1:0] a_sel;
  logic [DATA_W-1:0] d_sel;
  logic [DATA_W-1:0] merged;
  logic              misalign;
  logic              idle;

  assign t_in = store_type_t'(store_type);
  assign idle = (state_q == S_IDLE);

  // In IDLE the request is still on the inputs; afterwards use latched copies.
  assign t_sel = idle ? t_in  : type_q;
  assign a_sel = idle ? addr  : addr_q;
  assign d_sel = idle ? wdata : wdata_q;

`ifdef STORE_MISALIGN_CHECK_EN
  assign misalign = (t_in == ST_SH && addr[0]) ||
                    (t_in == ST_SW && addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  store_merge u_merge (
    .old_word (mem_rdata),
    .wdata    (d_sel),
    .stype    (t_sel),
    .lo       (a_sel[1:0]),
    .new_word (merged)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (t_in == ST_RSV || misalign)
            state_d = S_ERR;
          else if (t_in == ST_SW)
            state_d = S_WRITE;
          else
            state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_WRITE;
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      type_q    <= ST_SW;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idle && start) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        type_q  <= t_in;
      end
      if (state_d == S_RD_REQ || state_d == S_WRITE)
        mem_addr <= {a_sel[ADDR_W-1:2], 2'b00};
      if (state_d == S_WRITE)
        mem_wdata <= merged;
      mem_wr <= (state_d == S_WRITE);
      busy   <= (state_d != S_IDLE);
      done   <= (state_d == S_DONE) || (state_d == S_ERR);
      err    <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit (default build).
// Vector table plus reset and back-to-back sequences.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  store_type = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] cur_word = '0;

  int checks = 0;
  int failures = 0;

  logic        wr_a [16];
  logic [31:0] wa_a [16];
  logic [31:0] wd_a [16];
  logic        dn_a [16];
  logic        er_a [16];
  logic        bz_a [16];

  store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .store_type(store_type),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Registered-read memory stand-in returning the word set per test.
  always @(posedge clk) mem_rdata <= cur_word;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] mem;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wword;
    int          wcyc;
    int          dcyc;
    logic        e;
  } vec_t;

  vec_t v [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run(input int n, input bit hold,
                     input int sw_at, input int rst_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wr_a[k] = mem_wr;
      wa_a[k] = mem_addr;
      wd_a[k] = mem_wdata;
      dn_a[k] = done;
      er_a[k] = err;
      bz_a[k] = busy;
      @(posedge clk);
      #1;
      if (k == 0 && !hold) start = 1'b0;
      if (hold && k == sw_at) begin
        store_type = 2'd0;
        addr = 32'h400;
        wdata = 32'h0BADF00D;
      end
      if (hold && k == sw_at + 1) start = 1'b0;
      if (k == rst_at) reset = 1'b1;
      if (k == rst_at + 1) reset = 1'b0;
    end
  endtask

  task automatic analyze(input int n, input int from,
                         output int nwr, output int fwr,
                         output int fdn);
    nwr = 0;
    fwr = -1;
    fdn = -1;
    for (int k = from; k < n; k++) begin
      if (wr_a[k]) begin
        nwr++;
        if (fwr < 0) fwr = k;
      end
      if (dn_a[k] && fdn < 0) fdn = k;
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] m);
    @(posedge clk);
    #1;
    cur_word = m;
    store_type = t;
    addr = a;
    wdata = d;
    start = 1'b1;
  endtask

  initial begin
    int nwr, fwr, fdn;
    string nm;

    v[0] = '{2'd0, 32'h100, 32'hDEADBEEF, 32'h0,
             1, 32'h100, 32'hDEADBEEF, 1, 2, 1'b0};
    v[1] = '{2'd2, 32'h102, 32'h000000AA, 32'h11223344,
             1, 32'h100, 32'h11AA3344, 3, 4, 1'b0};
    v[2] = '{2'd1, 32'h206, 32'h0000CAFE, 32'h55667788,
             1, 32'h204, 32'hCAFE7788, 3, 4, 1'b0};
    v[3] = '{2'd3, 32'h300, 32'h12345678, 32'h0,
             0, 32'h0, 32'h0, -1, 1, 1'b1};
    v[4] = '{2'd1, 32'h201, 32'h0000BEEF, 32'hAABBCCDD,
             1, 32'h200, 32'hAABBBEEF, 3, 4, 1'b0};
    v[5] = '{2'd0, 32'h103, 32'h12345678, 32'h0,
             1, 32'h100, 32'h12345678, 1, 2, 1'b0};
    v[6] = '{2'd2, 32'h3, 32'hFFFFFF5A, 32'h0,
             1, 32'h0, 32'h5A000000, 3, 4, 1'b0};
    v[7] = '{2'd2, 32'h0, 32'h00000012, 32'hFFFFFFFF,
             1, 32'h0, 32'hFFFFFF12, 3, 4, 1'b0};
    v[8] = '{2'd1, 32'h0, 32'h1234ABCD, 32'h0,
             1, 32'h0, 32'h0000ABCD, 3, 4, 1'b0};
    v[9] = '{2'd2, 32'h1, 32'h00000077, 32'h11223344,
             1, 32'h0, 32'h11227744, 3, 4, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {29'd0, mem_wr, done, err},  32'h0);
    chk("reset_busy", {31'd0, busy},               32'h0);
    chk("reset_addr", mem_addr,                    32'h0);
    chk("reset_wdata", mem_wdata,                  32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(v[i].t, v[i].a, v[i].d, v[i].mem);
      run(8, 1'b0, -1, -1);
      analyze(8, 0, nwr, fwr, fdn);
      nm = $sformatf("v%0d", i);
      chk({nm, "_nwr"}, nwr, v[i].nwr);
      chk({nm, "_done_cyc"}, fdn, v[i].dcyc);
      chk({nm, "_busy1"}, {31'd0, bz_a[1]}, 32'h1);
      if (fdn >= 0 && fdn < 7) begin
        chk({nm, "_err"}, {31'd0, er_a[fdn]}, {31'd0, v[i].e});
        chk({nm, "_busy_off"}, {31'd0, bz_a[fdn + 1]}, 32'h0);
      end
      if (v[i].nwr > 0 && fwr >= 0) begin
        chk({nm, "_wr_cyc"}, fwr, v[i].wcyc);
        chk({nm, "_wr_addr"}, wa_a[fwr], v[i].waddr);
        chk({nm, "_wr_word"}, wd_a[fwr], v[i].wword);
      end
    end

    // Reset while an SB sits in RD_WAIT: nothing may follow.
    issue(2'd2, 32'h102, 32'h000000AA, 32'h11223344);
    run(8, 1'b0, -1, 1);
    analyze(8, 0, nwr, fwr, fdn);
    chk("rst_mid_nwr", nwr, 0);
    chk("rst_mid_done", fdn, -1);
    chk("rst_mid_busy", {31'd0, bz_a[3]}, 32'h0);

    issue(2'd0, 32'h100, 32'hDEADBEEF, 32'h0);
    run(8, 1'b0, -1, -1);
    analyze(8, 0, nwr, fwr, fdn);
    chk("post_rst_nwr", nwr, 1);
    chk("post_rst_done", fdn, 2);
    chk("post_rst_word", wd_a[1], 32'hDEADBEEF);

    // start held through an SH, then a SW in the first IDLE cycle.
    issue(2'd1, 32'h206, 32'h0000CAFE, 32'h55667788);
    run(12, 1'b1, 4, -1);
    analyze(5, 0, nwr, fwr, fdn);
    chk("hold_sh_nwr", nwr, 1);
    chk("hold_sh_done", fdn, 4);
    if (fwr >= 0) chk("hold_sh_word", wd_a[fwr], 32'hCAFE7788);
    analyze(12, 5, nwr, fwr, fdn);
    chk("b2b_nwr", nwr, 1);
    chk("b2b_wr_cyc", fwr, 6);
    chk("b2b_done", fdn, 7);
    if (fwr >= 0) begin
      chk("b2b_addr", wa_a[fwr], 32'h400);
      chk("b2b_word", wd_a[fwr], 32'h0BADF00D);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
